serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor, the sequential successor to our single-bit half adder. One full-adder cell (two half adders plus carry OR) is reused once per clock, LSB-first, with a registered carry. Operands are loaded on a start pulse; the result and flags come back after WIDTH cycles with a one-cycle done strobe. It serves datapath blocks that trade latency for gate count.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The requester raises start with sub/a/b; the adder returns sum/cout/ovf with a done strobe.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, a, b,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, a, b,
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell reused LSB-first, one bit per clock.
// Handshake: start is sampled only in IDLE; done pulses one cycle when sum/cout/ovf become valid.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_if.slave     bus,
  output logic [1:0]        o_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  // Full adder built from two half adders and a carry OR.
  logic w_ha1_s;
  logic w_ha1_c;
  logic w_s;
  logic w_ha2_c;
  logic w_c;

  assign w_ha1_s = r_a[0] ^ r_b[0];
  assign w_ha1_c = r_a[0] & r_b[0];
  assign w_s     = w_ha1_s ^ r_carry;
  assign w_ha2_c = w_ha1_s & r_carry;
  assign w_c     = w_ha1_c | w_ha2_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          if (r_cnt == LAST) begin
            // r_carry here is the carry into the MSB, w_c the carry out of it.
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign o_state  = r_state;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 2 and 16: vector table, protocol corner cases, random sweep.
module tb_serial_adder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [17:0] exp_q[$];

  serial_adder_if #(.WIDTH(8))  bus8();
  serial_adder_if #(.WIDTH(2))  bus2();
  serial_adder_if #(.WIDTH(16)) bus16();
  logic [1:0] st8, st2, st16;

  serial_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .bus(bus8),  .o_state(st8));
  serial_adder #(.WIDTH(2))  u_w2  (.clk(clk), .rst(rst), .bus(bus2),  .o_state(st2));
  serial_adder #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .bus(bus16), .o_state(st16));

  // Uniform views indexed by instance: 0 = WIDTH 8, 1 = WIDTH 2, 2 = WIDTH 16.
  logic [15:0] sum_v[3];
  logic        cout_v[3], ovf_v[3], busy_v[3], done_v[3];
  assign sum_v[0] = {8'h00, bus8.sum};
  assign sum_v[1] = {14'h0, bus2.sum};
  assign sum_v[2] = bus16.sum;
  assign cout_v[0] = bus8.cout;  assign cout_v[1] = bus2.cout;  assign cout_v[2] = bus16.cout;
  assign ovf_v[0]  = bus8.ovf;   assign ovf_v[1]  = bus2.ovf;   assign ovf_v[2]  = bus16.ovf;
  assign busy_v[0] = bus8.busy;  assign busy_v[1] = bus2.busy;  assign busy_v[2] = bus16.busy;
  assign done_v[0] = bus8.done;  assign done_v[1] = bus2.done;  assign done_v[2] = bus16.done;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int sel);
    case (sel)
      0: return 8;
      1: return 2;
      default: return 16;
    endcase
  endfunction

  // Reference: a + (sub ? ~b : b) + sub, overflow from operand/result signs.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic sub);
    logic [16:0] mask, aa, bb, full;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & mask;
    bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = aa + bb + {16'd0, sub};
    return {16'(full & mask), full[w], (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic set_in(input int sel, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic sub);
    case (sel)
      0: begin bus8.start = s;  bus8.a = a[7:0];  bus8.b = b[7:0];  bus8.sub = sub;  end
      1: begin bus2.start = s;  bus2.a = a[1:0];  bus2.b = b[1:0];  bus2.sub = sub;  end
      default: begin bus16.start = s; bus16.a = a; bus16.b = b; bus16.sub = sub; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic sub,
                    input logic [17:0] exp);
    int w, lat;
    logic [17:0] e, got;
    w = wid(sel);
    set_in(sel, 1'b1, a, b, sub);
    exp_q.push_back(exp);
    tick();
    set_in(sel, 1'b0, ~a, ~b, ~sub);
    chk("busy_after_accept", 32'(busy_v[sel]), 32'd1);
    lat = -1;
    for (int k = 1; k <= w + 4; k++) begin
      tick();
      if (done_v[sel]) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", 32'(lat), 32'(w));
    e   = exp_q.pop_front();
    got = {sum_v[sel], cout_v[sel], ovf_v[sel]};
    chk("result", 32'(got), 32'(e));
    chk("busy_in_done", 32'(busy_v[sel]), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done_v[sel]), 32'd0);
    chk("sum_held", 32'(sum_v[sel]), 32'(e[17:2]));
  endtask

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t[3];
    int nd;
    logic [15:0] ra, rb;
    logic        rs;
    logic [17:0] e;

    vecs[0] = '{0, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1};
    vecs[1] = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{0, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b0, 1'b0};
    vecs[3] = '{0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1};
    vecs[4] = '{1, 16'h0003, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{2, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    chk("reset_sum", 32'(bus8.sum), 32'd0);
    chk("reset_busy_done", {30'd0, bus8.busy, bus8.done}, 32'd0);
    chk("reset_state", 32'(st8), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sub, {vecs[i].sum, vecs[i].cout, vecs[i].ovf});

    // Asynchronous reset while bit 3 is being processed.
    set_in(0, 1'b1, 16'h5A, 16'h3C, 1'b0);
    tick();
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_sum", 32'(bus8.sum), 32'd0);
    chk("rst_mid_flags", {28'd0, bus8.cout, bus8.ovf, bus8.busy, bus8.done}, 32'd0);
    chk("rst_mid_state", 32'(st8), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    op(0, 16'h01, 16'h01, 1'b0, {16'h0002, 1'b0, 1'b0});

    // start pulses during RUN and DONE must be ignored.
    set_in(0, 1'b1, 16'h5A, 16'h3C, 1'b0);
    exp_q.push_back({16'h0096, 1'b0, 1'b1});
    tick();
    set_in(0, 1'b0, 16'h5A, 16'h3C, 1'b0);
    tick(); tick(); tick();
    set_in(0, 1'b1, 16'h11, 16'h22, 1'b1);
    tick();
    set_in(0, 1'b0, 16'h11, 16'h22, 1'b1);
    nd = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus8.done) begin
        nd = k + 4;
        break;
      end
    end
    chk("proto_latency", 32'(nd), 32'd8);
    e = exp_q.pop_front();
    chk("proto_result", {14'd0, bus8.sum, bus8.cout, bus8.ovf}, 32'(e[9:0]));
    set_in(0, 1'b1, 16'h77, 16'h01, 1'b1);
    tick();
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus8.done || bus8.busy) nd++;
      tick();
    end
    chk("proto_no_second_op", 32'(nd), 32'd0);
    chk("proto_sum_held", 32'(bus8.sum), 32'h96);

    // start held high: one operation every WIDTH+2 cycles.
    set_in(0, 1'b1, 16'h01, 16'h02, 1'b0);
    nd = 0;
    for (int k = 0; k < 40 && nd < 3; k++) begin
      tick();
      if (bus8.done) begin
        t[nd] = k;
        nd++;
      end
    end
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("held_strobes", 32'(nd), 32'd3);
    if (nd == 3) begin
      chk("held_spacing_1", 32'(t[1] - t[0]), 32'd10);
      chk("held_spacing_2", 32'(t[2] - t[1]), 32'd10);
    end
    chk("held_sum", 32'(bus8.sum), 32'h03);
    repeat (12) tick();

    // Random operands at every width against the reference model.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 8; n++) begin
        ra = 16'($urandom_range(0, 65535)) & 16'((32'd1 << wid(s)) - 1);
        rb = 16'($urandom_range(0, 65535)) & 16'((32'd1 << wid(s)) - 1);
        rs = 1'($urandom_range(0, 1));
        op(s, ra, rb, rs, model(wid(s), ra, rb, rs));
      end
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
